// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: condition encodings.
package branch_resolve_unit_pkg;

  typedef logic [2:0] branch_op_t;

  localparam branch_op_t BR_EQ   = 3'b000;
  localparam branch_op_t BR_NE   = 3'b001;
  localparam branch_op_t BR_LT   = 3'b010;
  localparam branch_op_t BR_GE   = 3'b011;
  localparam branch_op_t BR_LTU  = 3'b100;
  localparam branch_op_t BR_GEU  = 3'b101;
  localparam branch_op_t BR_JMP0 = 3'b110;
  localparam branch_op_t BR_JMP1 = 3'b111;

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational branch condition evaluation at full operand width.
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  branch_op_t       op_code,
  output logic             taken
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (op_a == op_b);
  assign lt_s = ($signed(op_a) < $signed(op_b));
  assign lt_u = (op_a < op_b);

  // Decode the condition; both jump encodings are unconditionally taken.
  always_comb begin
    taken = 1'b1;
    unique case (op_code)
      BR_EQ:   taken = eq;
      BR_NE:   taken = !eq;
      BR_LT:   taken = lt_s;
      BR_GE:   taken = !lt_s;
      BR_LTU:  taken = lt_u;
      BR_GEU:  taken = !lt_u;
      BR_JMP0: taken = 1'b1;
      BR_JMP1: taken = 1'b1;
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolver: single-entry output buffer with valid/ready,
// mispredict detection, flush, and saturating taken/mispredict counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned TAG_WIDTH = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic [2:0]           op_code,
  input  logic                 pred_taken,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_taken,
  output logic                 out_mispredict,
  output logic [TAG_WIDTH-1:0] out_tag,
  input  logic                 clear_counts,
  output logic [CNT_WIDTH-1:0] taken_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  logic                 cond_taken;
  logic                 accept;
  logic                 handoff;

  logic                 valid_q, valid_d;
  logic                 taken_q, taken_d;
  logic                 misp_q, misp_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_WIDTH-1:0] misp_cnt_q, misp_cnt_d;

  branch_cond_eval #(
    .WIDTH (WIDTH)
  ) u_cond_eval (
    .op_a    (op_a),
    .op_b    (op_b),
    .op_code (branch_op_t'(op_code)),
    .taken   (cond_taken)
  );

  // No skid entry: accept only when the buffer is empty or draining now.
  assign in_ready = RST_N && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign handoff  = valid_q && out_ready;

  // Output buffer next state; flush wins over a same-cycle accept.
  always_comb begin
    valid_d = valid_q;
    taken_d = taken_q;
    misp_d  = misp_q;
    tag_d   = tag_q;
    if (handoff) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      valid_d = 1'b1;
      taken_d = cond_taken;
      misp_d  = cond_taken ^ pred_taken;
      tag_d   = in_tag;
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  // Statistics: count on hand-off (even during flush), saturate, clear wins.
  always_comb begin
    taken_cnt_d = taken_cnt_q;
    misp_cnt_d  = misp_cnt_q;
    if (clear_counts) begin
      taken_cnt_d = '0;
      misp_cnt_d  = '0;
    end else if (handoff) begin
      if (taken_q && (taken_cnt_q != {CNT_WIDTH{1'b1}})) begin
        taken_cnt_d = taken_cnt_q + 1'b1;
      end
      if (misp_q && (misp_cnt_q != {CNT_WIDTH{1'b1}})) begin
        misp_cnt_d = misp_cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      valid_q     <= 1'b0;
      taken_q     <= 1'b0;
      misp_q      <= 1'b0;
      tag_q       <= '0;
      taken_cnt_q <= '0;
      misp_cnt_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      taken_q     <= taken_d;
      misp_q      <= misp_d;
      tag_q       <= tag_d;
      taken_cnt_q <= taken_cnt_d;
      misp_cnt_q  <= misp_cnt_d;
    end
  end

  assign out_valid        = valid_q;
  assign out_taken        = taken_q;
  assign out_mispredict   = misp_q;
  assign out_tag          = tag_q;
  assign taken_count      = taken_cnt_q;
  assign mispredict_count = misp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit with a behavioural reference model.
module tb_branch_resolve_unit;

  localparam int W  = 16;
  localparam int TW = 4;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a, op_b;
  logic [2:0]    op_code;
  logic          pred_taken;
  logic [TW-1:0] in_tag;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic          out_taken;
  logic          out_mispredict;
  logic [TW-1:0] out_tag;
  logic          clear_counts;
  logic [CW-1:0] taken_count;
  logic [CW-1:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_valid, m_taken, m_misp;
  int m_tag, m_tc, m_mc;

  branch_resolve_unit #(
    .WIDTH     (W),
    .TAG_WIDTH (TW),
    .CNT_WIDTH (CW)
  ) dut (
    .CLK              (clk),
    .RST_N            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .op_a             (op_a),
    .op_b             (op_b),
    .op_code          (op_code),
    .pred_taken       (pred_taken),
    .in_tag           (in_tag),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_taken        (out_taken),
    .out_mispredict   (out_mispredict),
    .out_tag          (out_tag),
    .clear_counts     (clear_counts),
    .taken_count      (taken_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  function automatic int sval(logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction

  function automatic bit ref_taken(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      3'd0:    return int'(a) == int'(b);
      3'd1:    return int'(a) != int'(b);
      3'd2:    return sval(a) < sval(b);
      3'd3:    return sval(a) >= sval(b);
      3'd4:    return int'(a) < int'(b);
      3'd5:    return int'(a) >= int'(b);
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit model_ready();
    return rst_n && (!m_valid || out_ready);
  endfunction

  // Advance one clock, stepping the model from the pre-edge inputs.
  task automatic tick();
    bit acc, ho, nt;
    acc = in_valid && model_ready() && !flush;
    ho  = m_valid && out_ready;
    nt  = ref_taken(op_code, op_a, op_b);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_valid = 0; m_taken = 0; m_misp = 0; m_tag = 0; m_tc = 0; m_mc = 0;
    end else begin
      if (clear_counts) begin
        m_tc = 0; m_mc = 0;
      end else if (ho) begin
        m_tc = (m_tc + m_taken > CNT_MAX) ? CNT_MAX : m_tc + m_taken;
        m_mc = (m_mc + m_misp > CNT_MAX) ? CNT_MAX : m_mc + m_misp;
      end
      if (acc) begin
        m_taken = nt;
        m_misp  = nt != pred_taken;
        m_tag   = int'(in_tag);
      end
      if (flush)    m_valid = 0;
      else if (acc) m_valid = 1;
      else if (ho)  m_valid = 0;
    end
  endtask

  task automatic drive(bit v, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, bit p,
                       logic [TW-1:0] t);
    in_valid = v; op_code = op; op_a = a; op_b = b; pred_taken = p; in_tag = t;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %b want 0", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_taken, out_mispredict, out_tag} !== '0 ||
        taken_count !== '0 || mispredict_count !== '0) begin
      errors++;
      $display("FAIL reset_state got v%b t%b m%b tag%h tc%h mc%h want all 0",
               out_valid, out_taken, out_mispredict, out_tag, taken_count, mispredict_count);
    end
    rst_n = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_signed_unsigned();
    out_ready = 1;
    drive(1, 3'b010, 16'h8000, 16'h0001, 0, 4'h3);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_tag !== 4'h3) begin
      errors++;
      $display("FAIL lt_signed got v%b t%b tag%h want v1 t1 tag3", out_valid, out_taken, out_tag);
    end
    drive(1, 3'b100, 16'h8000, 16'h0001, 0, 4'h4);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_taken !== 1'b0 || out_tag !== 4'h4) begin
      errors++;
      $display("FAIL ltu got v%b t%b tag%h want v1 t0 tag4", out_valid, out_taken, out_tag);
    end
    drive(0, 3'b000, 0, 0, 0, 0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_mispredict();
    clear_counts = 1;
    tick();
    clear_counts = 0;
    drive(1, 3'b000, 16'h1234, 16'h1234, 0, 4'h5);
    tick();
    checks++;
    if (out_taken !== 1'b1 || out_mispredict !== 1'b1 || taken_count !== 0) begin
      errors++;
      $display("FAIL eq_mispredict got t%b m%b tc%0d want t1 m1 tc0",
               out_taken, out_mispredict, taken_count);
    end
    drive(0, 3'b000, 0, 0, 0, 0);
    tick();
    checks++;
    if (taken_count !== 4'd1 || mispredict_count !== 4'd1) begin
      errors++;
      $display("FAIL count_after_handoff got tc%0d mc%0d want 1 1", taken_count, mispredict_count);
    end
    drive(1, 3'b110, 16'hBEEF, 16'h0000, 1, 4'h6);
    tick();
    checks++;
    if (out_taken !== 1'b1 || out_mispredict !== 1'b0) begin
      errors++;
      $display("FAIL jump got t%b m%b want t1 m0", out_taken, out_mispredict);
    end
    drive(0, 3'b000, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] held_tag;
    int tc0, mc0;
    out_ready = 0;
    drive(1, 3'b011, 16'h0005, 16'hFFFF, 0, 4'h9);
    tick();
    held_tag = out_tag;
    tc0 = int'(taken_count);
    mc0 = int'(mispredict_count);
    drive(1, 3'b001, 16'h0001, 16'h0002, 1, 4'hA);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_ready cyc%0d got %b want 0", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_mispredict !== 1'b1 ||
          out_tag !== 4'h9 || int'(taken_count) != tc0 || int'(mispredict_count) != mc0) begin
        errors++;
        $display("FAIL stall_hold cyc%0d got v%b t%b m%b tag%h tc%0d mc%0d want 1 1 1 9 %0d %0d",
                 i, out_valid, out_taken, out_mispredict, out_tag, taken_count,
                 mispredict_count, tc0, mc0);
      end
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL release_ready got %b want 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'hA || out_taken !== 1'b1 ||
        out_mispredict !== 1'b0 || int'(taken_count) != tc0 + 1) begin
      errors++;
      $display("FAIL b2b got v%b tag%h t%b m%b tc%0d want v1 tagA t1 m0 tc%0d",
               out_valid, out_tag, out_taken, out_mispredict, taken_count, tc0 + 1);
    end
    drive(0, 3'b000, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_flush();
    int tc0;
    out_ready = 0;
    drive(1, 3'b110, 0, 0, 0, 4'h1);
    tick();
    tc0 = int'(taken_count);
    drive(1, 3'b110, 0, 0, 0, 4'h2);
    flush = 1;
    tick();
    flush = 0;
    checks++;
    if (out_valid !== 1'b0 || int'(taken_count) != tc0) begin
      errors++;
      $display("FAIL flush_held got v%b tc%0d want v0 tc%0d", out_valid, taken_count, tc0);
    end
    drive(1, 3'b110, 0, 0, 1, 4'h3);
    tick();
    tc0 = int'(taken_count);
    out_ready = 1;
    flush = 1;
    tick();
    flush = 0;
    checks++;
    if (out_valid !== 1'b0 || int'(taken_count) != tc0 + 1) begin
      errors++;
      $display("FAIL flush_handoff got v%b tc%0d want v0 tc%0d", out_valid, taken_count, tc0 + 1);
    end
    drive(0, 3'b000, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_saturation();
    out_ready = 1;
    clear_counts = 1;
    tick();
    clear_counts = 0;
    drive(1, 3'b111, 16'h0, 16'h0, 1, 4'h7);
    repeat (17) tick();
    drive(0, 3'b000, 0, 0, 0, 0);
    tick();
    checks++;
    if (taken_count !== 4'hF || mispredict_count !== 4'h0) begin
      errors++;
      $display("FAIL saturate got tc%h mc%h want F 0", taken_count, mispredict_count);
    end
    drive(1, 3'b110, 0, 0, 0, 4'h8);
    tick();
    drive(0, 3'b000, 0, 0, 0, 0);
    clear_counts = 1;
    tick();
    clear_counts = 0;
    checks++;
    if (taken_count !== 4'h0 || mispredict_count !== 4'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_priority got tc%h mc%h v%b want 0 0 0",
               taken_count, mispredict_count, out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom), W'($urandom), W'($urandom),
            1'($urandom), TW'($urandom));
      if ($urandom_range(0, 3) == 0) op_b = op_a;
      if ($urandom_range(0, 3) == 0) op_a = {1'b1, op_a[W-2:0]};
      out_ready    = $urandom_range(0, 2) != 0;
      flush        = $urandom_range(0, 15) == 0;
      clear_counts = $urandom_range(0, 40) == 0;
      rst_n        = $urandom_range(0, 60) != 0;
      #1;
      checks++;
      if (in_ready !== model_ready()) begin
        errors++; $display("FAIL rand_ready i%0d got %b want %b", i, in_ready, model_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_valid || out_taken !== m_taken || out_mispredict !== m_misp ||
          int'(out_tag) != m_tag || int'(taken_count) != m_tc ||
          int'(mispredict_count) != m_mc) begin
        errors++;
        $display("FAIL rand_out i%0d got v%b t%b m%b tag%0d tc%0d mc%0d want %b %b %b %0d %0d %0d",
                 i, out_valid, out_taken, out_mispredict, out_tag, taken_count,
                 mispredict_count, m_valid, m_taken, m_misp, m_tag, m_tc, m_mc);
      end
    end
    rst_n = 1; flush = 0; clear_counts = 0;
    drive(0, 3'b000, 0, 0, 0, 0);
    out_ready = 1;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1;
    drive(1, 3'b110, 0, 0, 0, 4'hC);
    tick();
    tick();
    drive(0, 3'b000, 0, 0, 0, 0);
    out_ready = 0;
    rst_n = 0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ready got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_taken !== 1'b0 || out_mispredict !== 1'b0 ||
        out_tag !== '0 || taken_count !== '0 || mispredict_count !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state got v%b t%b m%b tag%h tc%h mc%h rdy%b want all 0",
               out_valid, out_taken, out_mispredict, out_tag, taken_count,
               mispredict_count, in_ready);
    end
    rst_n = 1;
    drive(1, 3'b000, 16'h00AA, 16'h00AA, 1, 4'hD);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_mispredict !== 1'b0 ||
        out_tag !== 4'hD) begin
      errors++;
      $display("FAIL rst_first_accept got v%b t%b m%b tag%h want 1 1 0 D",
               out_valid, out_taken, out_mispredict, out_tag);
    end
    drive(0, 3'b000, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; flush = 0; out_ready = 0; clear_counts = 0;
    drive(0, 3'b000, 0, 0, 0, 0);
    m_valid = 0; m_taken = 0; m_misp = 0; m_tag = 0; m_tc = 0; m_mc = 0;
    test_reset();
    test_signed_unsigned();
    test_mispredict();
    test_back_to_back();
    test_flush();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
